// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU request arbiter: FSM state encoding and
// the legal range of the ALU latency parameter.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int ALU_LAT_MIN = 1;
  localparam int ALU_LAT_MAX = 15;
  localparam int CNT_W       = 4;

  // Terminal latency-counter value; out-of-range latencies are clamped.
  function automatic logic [CNT_W-1:0] cnt_last(input int lat);
    int l;
    l = lat;
    if (l < ALU_LAT_MIN) l = ALU_LAT_MIN;
    if (l > ALU_LAT_MAX) l = ALU_LAT_MAX;
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: i_ptr names the requester that wins a tie.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req[0] && i_req[1]) begin
      o_gnt = i_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU, holds the operation for
// ALU_LAT cycles, then returns the captured result with the winner's id.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [4:0]       op0,
  input  logic [4:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAT_LAST = cnt_last(ALU_LAT);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ptr;
  logic             r_winner;
  logic [1:0]       w_gnt;

  rr_arb2 u_rr (
    .i_req (({req1, req0})),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ptr      <= 1'b0;
      r_winner   <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_enable <= 1'b0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_data   <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|w_gnt) begin
            alu_opcode <= w_gnt[1] ? op1 : op0;
            alu_a      <= w_gnt[1] ? a1  : a0;
            alu_b      <= w_gnt[1] ? b1  : b0;
            gnt0       <= w_gnt[0];
            gnt1       <= w_gnt[1];
            r_winner   <= w_gnt[1];
            // Favour the other requester on the next tie.
            r_ptr      <= w_gnt[0];
            alu_enable <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == LAT_LAST) begin
            res_data   <= alu_out;
            res_id     <= r_winner;
            res_valid  <= 1'b1;
            alu_enable <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LAT=1 and one at
// ALU_LAT=3, sharing clock, reset and requester inputs.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [4:0]   op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic         gnt0_1, gnt1_1, en_1, rv_1, rid_1, busy_1;
  logic [4:0]   opc_1;
  logic [W-1:0] aa_1, ab_1, ao_1, rd_1;
  logic         gnt0_3, gnt1_3, en_3, rv_3, rid_3, busy_3;
  logic [4:0]   opc_3;
  logic [W-1:0] aa_3, ab_3, ao_3, rd_3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ao_1 = en_1 ? aa_1 + ab_1 : '0;
  assign ao_3 = en_3 ? aa_3 + ab_3 : '0;

  alu_arbiter #(.ALU_LAT(1), .WIDTH(W)) u1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0_1), .gnt1(gnt1_1),
    .alu_opcode(opc_1), .alu_a(aa_1), .alu_b(ab_1), .alu_enable(en_1),
    .alu_out(ao_1), .res_valid(rv_1), .res_id(rid_1), .res_data(rd_1),
    .busy(busy_1)
  );

  alu_arbiter #(.ALU_LAT(3), .WIDTH(W)) u3 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0_3), .gnt1(gnt1_3),
    .alu_opcode(opc_3), .alu_a(aa_3), .alu_b(ab_3), .alu_enable(en_3),
    .alu_out(ao_3), .res_valid(rv_3), .res_id(rid_3), .res_data(rd_3),
    .busy(busy_3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req0 = 1'b1;
    a0   = 32'hFFFF_FFFF;
    tick();
    tick();
    checks++;
    if (busy_1 !== 1'b0 || gnt0_1 !== 1'b0 || gnt1_1 !== 1'b0 || en_1 !== 1'b0 ||
        rv_1 !== 1'b0 || rid_1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b gnt0=%b gnt1=%b en=%b rv=%b rid=%b, want all 0",
               busy_1, gnt0_1, gnt1_1, en_1, rv_1, rid_1);
    end
    checks++;
    if (opc_1 !== 5'd0 || aa_1 !== '0 || ab_1 !== '0 || rd_1 !== '0) begin
      errors++;
      $display("FAIL reset_data: opc=%h a=%h b=%h rd=%h, want 0", opc_1, aa_1, ab_1, rd_1);
    end
    req0 = 1'b0;
    a0   = '0;
    rst  = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1; op0 = 5'd0; a0 = 32'h0F0F_0F0F; b0 = 32'h0F0F_0F0F;
    tick();
    req0 = 1'b0;
    checks++;
    if (gnt0_1 !== 1'b1 || gnt1_1 !== 1'b0 || en_1 !== 1'b1 || busy_1 !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: gnt0=%b gnt1=%b en=%b busy=%b, want 1 0 1 1",
               gnt0_1, gnt1_1, en_1, busy_1);
    end
    checks++;
    if (aa_1 !== 32'h0F0F_0F0F || ab_1 !== 32'h0F0F_0F0F || opc_1 !== 5'd0) begin
      errors++;
      $display("FAIL single_latch: a=%h b=%h opc=%h, want 0f0f0f0f 0f0f0f0f 00", aa_1, ab_1, opc_1);
    end
    tick();
    checks++;
    if (rv_1 !== 1'b1 || rid_1 !== 1'b0 || rd_1 !== 32'h1E1E_1E1E || gnt0_1 !== 1'b0 || en_1 !== 1'b0) begin
      errors++;
      $display("FAIL single_result: rv=%b rid=%b rd=%h gnt0=%b en=%b, want 1 0 1e1e1e1e 0 0",
               rv_1, rid_1, rd_1, gnt0_1, en_1);
    end
    tick();
    checks++;
    if (rv_1 !== 1'b0 || busy_1 !== 1'b0 || rd_1 !== 32'h1E1E_1E1E) begin
      errors++;
      $display("FAIL single_after: rv=%b busy=%b rd=%h, want 0 0 1e1e1e1e", rv_1, busy_1, rd_1);
    end
  endtask

  task automatic test_contention();
    int ng, nr;
    logic g_seq [4];
    logic r_seq [4];
    logic [W-1:0] d_seq [4];
    logic exp_id [4];
    logic [W-1:0] exp_d [4];
    logic both;
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_d  = '{32'd3, 32'd30, 32'd3, 32'd30};
    ng = 0; nr = 0; both = 1'b0;
    do_reset();
    a0 = 32'd1;  b0 = 32'd2;  op0 = 5'd1;
    a1 = 32'd10; b1 = 32'd20; op1 = 5'd2;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (gnt0_1 && gnt1_1) both = 1'b1;
      if ((gnt0_1 || gnt1_1) && ng < 4) begin g_seq[ng] = gnt1_1; ng++; end
      if (rv_1 && nr < 4) begin r_seq[nr] = rid_1; d_seq[nr] = rd_1; nr++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (both !== 1'b0) begin
      errors++;
      $display("FAIL contention_both: both grants seen=%b, want 0", both);
    end
    checks++;
    if (ng != 4 || nr != 4) begin
      errors++;
      $display("FAIL contention_count: grants=%0d results=%0d, want 4 4", ng, nr);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (g_seq[k] !== exp_id[k] || r_seq[k] !== exp_id[k] || d_seq[k] !== exp_d[k]) begin
          errors++;
          $display("FAIL contention_%0d: gnt_id=%b res_id=%b rd=%0d, want %b %b %0d",
                   k, g_seq[k], r_seq[k], d_seq[k], exp_id[k], exp_id[k], exp_d[k]);
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_latency();
    int en_cnt, rv_at;
    en_cnt = 0; rv_at = -1;
    do_reset();
    req1 = 1'b1; op1 = 5'd3; a1 = 32'd5; b1 = 32'd7;
    for (int c = 0; c < 7; c++) begin
      tick();
      req1 = 1'b0;
      if (en_3) en_cnt++;
      if (rv_3 && rv_at < 0) rv_at = c;
      if (c == 0) begin
        checks++;
        if (gnt1_3 !== 1'b1 || gnt0_3 !== 1'b0 || opc_3 !== 5'd3) begin
          errors++;
          $display("FAIL lat_grant: gnt1=%b gnt0=%b opc=%h, want 1 0 03", gnt1_3, gnt0_3, opc_3);
        end
      end
    end
    checks++;
    if (en_cnt != 3) begin
      errors++;
      $display("FAIL lat_enable: enable cycles=%0d, want 3", en_cnt);
    end
    // Observation c follows edge c+1 after the sampling edge: res_valid seen
    // on the fourth edge means it was driven after the third.
    checks++;
    if (rv_at != 3) begin
      errors++;
      $display("FAIL lat_valid: res_valid after sample edge+%0d, want +3", rv_at);
    end
    checks++;
    if (rd_3 !== 32'd12 || rid_3 !== 1'b1) begin
      errors++;
      $display("FAIL lat_result: rd=%0d rid=%b, want 12 1", rd_3, rid_3);
    end
  endtask

  task automatic test_ignored();
    int n_g1, n_rv;
    n_g1 = 0; n_rv = 0;
    do_reset();
    req0 = 1'b1; a0 = 32'd4; b0 = 32'd4;
    tick();
    req0 = 1'b0;
    req1 = 1'b1;
    if (gnt1_1) n_g1++;
    if (rv_1) n_rv++;
    tick();
    req1 = 1'b0;
    if (gnt1_1) n_g1++;
    if (rv_1) n_rv++;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (gnt1_1) n_g1++;
      if (rv_1) n_rv++;
    end
    checks++;
    if (n_g1 != 0 || n_rv != 1) begin
      errors++;
      $display("FAIL ignored: gnt1 pulses=%0d results=%0d, want 0 1", n_g1, n_rv);
    end
    checks++;
    if (rd_1 !== 32'd8 || rid_1 !== 1'b0) begin
      errors++;
      $display("FAIL ignored_data: rd=%0d rid=%b, want 8 0", rd_1, rid_1);
    end
  endtask

  task automatic test_reset_midop();
    int n_rv;
    n_rv = 0;
    do_reset();
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd1;
    tick();
    req0 = 1'b0;
    tick();
    checks++;
    if (busy_3 !== 1'b1 || en_3 !== 1'b1) begin
      errors++;
      $display("FAIL midop_exec: busy=%b en=%b, want 1 1", busy_3, en_3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (rv_3) n_rv++;
    checks++;
    if (busy_3 !== 1'b0 || en_3 !== 1'b0 || rv_3 !== 1'b0) begin
      errors++;
      $display("FAIL midop_abort: busy=%b en=%b rv=%b, want 0 0 0", busy_3, en_3, rv_3);
    end
    req0 = 1'b1; req1 = 1'b1; a0 = 32'd2; b0 = 32'd2;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (gnt0_3 !== 1'b1 || gnt1_3 !== 1'b0) begin
      errors++;
      $display("FAIL midop_priority: gnt0=%b gnt1=%b, want 1 0", gnt0_3, gnt1_3);
    end
    checks++;
    if (n_rv != 0) begin
      errors++;
      $display("FAIL midop_novalid: results=%0d, want 0", n_rv);
    end
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (rd_3 !== 32'd4 || busy_3 !== 1'b0) begin
      errors++;
      $display("FAIL midop_next: rd=%0d busy=%b, want 4 0", rd_3, busy_3);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_latency();
    test_ignored();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ALU_LAT, default 1, number of cycles alu_enable is held before alu_out is captured (legal range 1..15).
REQ-002 Parameter: WIDTH, default 32, operand and result width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Ports: req0, req1  input  1 each  requester 0/1 operation request.
REQ-006 Ports: op0, op1  input  5 each  requester opcode.
REQ-007 Ports: a0, b0, a1, b1  input  WIDTH each  requester operands.
REQ-008 Ports: gnt0, gnt1  output  1 each  one-cycle grant/accept pulse.
REQ-009 Ports: alu_opcode  output  5,  alu_a, alu_b  output  WIDTH  latched operation driven to the shared ALU.
REQ-010 Port: alu_enable  output  1  ALU enable.
REQ-011 Port: alu_out  input  WIDTH  ALU result.
REQ-012 Ports: res_valid  output  1,  res_id  output  1,  res_data  output  WIDTH  result return.
REQ-013 Port: busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and DONE only.
REQ-015 In IDLE, on an edge with req0 or req1 high, the block SHALL latch the winner's opcode/operands into alu_opcode/alu_a/alu_b, set gnt of the winner high for exactly the next cycle, set alu_enable high, clear the latency counter and enter EXEC.
REQ-016 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; with one request, it wins regardless of pointer.
REQ-017 The round-robin pointer SHALL update only on a grant.
REQ-018 In EXEC the counter SHALL increment each edge; on the edge where counter equals ALU_LAT-1 the block SHALL capture alu_out into res_data, set res_id to the winner, drive alu_enable low and enter DONE.
REQ-019 In DONE, res_valid SHALL be high for exactly that one cycle; the next edge SHALL return to IDLE.
REQ-020 Request-sampled edge to res_valid high SHALL be ALU_LAT+1 cycles; minimum issue interval SHALL be ALU_LAT+2 cycles.
REQ-021 req inputs SHALL be ignored outside IDLE; a requester keeping req high after its gnt is treated as a new request on the next IDLE edge.
REQ-022 alu_opcode/alu_a/alu_b and res_data/res_id SHALL hold their last values until next overwritten.
REQ-023 gnt0 and gnt1 SHALL never be high in the same cycle; at most one operation SHALL be in flight.

Reset
REQ-024 When rst is high on an edge, state SHALL become IDLE and all outputs, counter and latched values SHALL become 0; the round-robin pointer SHALL favour requester 0.
REQ-025 rst during EXEC or DONE SHALL abort the operation with no res_valid pulse.
REQ-026 rst SHALL take priority over a simultaneous request.

Structure
REQ-027 State encoding constants and ALU_LAT bound SHALL live in a shared package alu_ctrl_pkg used by the processor top.
REQ-028 The round-robin selector SHALL be a sub-module rr_arb2 (two requests, pointer in, one-hot grant out); FSM, counter and latches stay in alu_arbiter.

Verification (bench ALU model: alu_out = alu_a + alu_b when alu_enable)
REQ-029 Single request: req0=1, a0=b0=0x0F0F0F0F, op0=00000, ALU_LAT=1 -> gnt0 one cycle later, res_valid two cycles after sampling, res_id=0, res_data=0x1E1E1E1E.
REQ-030 Contention: req0=req1=1 held after reset -> grants alternate 0,1,0,1; res_id sequence matches; no cycle with both gnts.
REQ-031 Latency sweep: ALU_LAT=3, req1 with a1=5, b1=7 -> alu_enable high 3 cycles, res_valid 4 cycles after sampling, res_data=12.
REQ-032 Ignored requests: req1 asserted only during EXEC and dropped before IDLE -> no gnt1, no extra result.
REQ-033 Reset mid-op: rst high during EXEC -> next cycle busy=0, alu_enable=0, no res_valid; subsequent req0 gets priority even if req1 also high.
